arb_mux: RTL and testbench

Parametrised N-channel arbitrating multiplexer with a valid/ready handshake on every input and on the output. It selects one of `CHANNELS` requesting sources each cycle using round-robin or fixed-priority arbitration and registers the winner's data. It sits between several bus masters or producers and a single downstream consumer. It replaces fixed-select Mux2/Mux4/Mux8 instances wherever the select must be computed from requests rather than driven by control.

---
 rtl/arb_mux.sv | 51 +++++
 tb/tb_arb_mux.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// arb_mux: arbitrating N-channel mux, round-robin or fixed priority, with a registered valid/ready output.
module arb_mux #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHANNELS    = 4,
  parameter int SELECT_SIZE = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           mode_i,
  input  logic [CHANNELS-1:0]            valid_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
  output logic [CHANNELS-1:0]            ready_o,
  output logic                           valid_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [SELECT_SIZE-1:0]         select_o,
  input  logic                           ready_i
);
  logic [SELECT_SIZE-1:0] last, low, above, g;
  logic above_hit, grant;
  // Round-robin winner is the lowest requester above last, else wrap to the lowest overall.
  always_comb begin
    low = '0;
    above = '0;
    above_hit = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (valid_i[i]) low = SELECT_SIZE'(i);
      if (valid_i[i] && SELECT_SIZE'(i) > last) begin
        above = SELECT_SIZE'(i);
        above_hit = 1'b1;
      end
    end
  end
  assign g = (mode_i || !above_hit) ? low : above;
  assign grant = !reset_i && (!valid_o || ready_i) && |valid_i;
  assign ready_o = grant ? CHANNELS'(1) << g : '0;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
      data_o <= '0;
      select_o <= '0;
      last <= SELECT_SIZE'(CHANNELS - 1);
    end else if (grant) begin
      valid_o <= 1'b1;
      data_o <= data_i[int'(g)*DATA_WIDTH +: DATA_WIDTH];
      select_o <= g;
      if (!mode_i) last <= g;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: scoreboard bench for arb_mux with a high-level arbitration model and a 3-channel wrap instance.
module tb_arb_mux;
  localparam int DW = 16, C = 4, S = 2;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset_i = 1, mode_i = 0, ready_i = 1;
  logic [C-1:0] valid_i = '0;
  logic [C*DW-1:0] data_i = '0;
  logic [C-1:0] ready_o;
  logic valid_o;
  logic [DW-1:0] data_o;
  logic [S-1:0] select_o;
  arb_mux #(.DATA_WIDTH(DW), .CHANNELS(C), .SELECT_SIZE(S)) dut (
    .clk_i(clk), .reset_i(reset_i), .mode_i(mode_i), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .select_o(select_o), .ready_i(ready_i)
  );
  logic [2:0] valid3 = 3'b101;
  logic [3*DW-1:0] data3 = {16'hC002, 16'hC001, 16'hC000};
  logic [2:0] ready3;
  logic valid3_o;
  logic [DW-1:0] data3_o;
  logic [1:0] sel3;
  arb_mux #(.DATA_WIDTH(DW), .CHANNELS(3), .SELECT_SIZE(2)) dut3 (
    .clk_i(clk), .reset_i(reset_i), .mode_i(1'b0), .valid_i(valid3), .data_i(data3),
    .ready_o(ready3), .valid_o(valid3_o), .data_o(data3_o), .select_o(sel3), .ready_i(1'b1)
  );
  typedef struct {logic [S-1:0] sel; logic [DW-1:0] data;} word_t;
  word_t sb[$];
  int total = 0, bad = 0;
  int m_last = C - 1, last_g = -1;
  bit m_valid = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int winner(logic [C-1:0] v, bit fixed, int last);
    if (fixed) begin
      for (int k = 0; k < C; k++) if (v[k]) return k;
    end else begin
      for (int off = 1; off <= C; off++) if (v[(last + off) % C]) return (last + off) % C;
    end
    return -1;
  endfunction
  task automatic step(bit rst, bit md, logic [C-1:0] v, bit rdy, logic [C*DW-1:0] d);
    @(negedge clk);
    reset_i = rst; mode_i = md; valid_i = v; ready_i = rdy; data_i = d;
    #1;
    chk("valid_o", valid_o, m_valid);
    if (rst) begin
      chk("ready_o_in_reset", ready_o, 0);
      sb.delete();
      m_valid = 0;
      m_last = C - 1;
      last_g = -1;
    end else begin
      int g;
      logic [C-1:0] er;
      g = (m_valid && !rdy) ? -1 : winner(v, md, m_last);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("ready_o", ready_o, er);
      if (g >= 0) begin
        sb.push_back('{S'(g), d[g*DW +: DW]});
        m_valid = 1;
        if (!md) m_last = g;
      end else if (rdy) m_valid = 0;
      last_g = g;
    end
  endtask
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_i && valid_o && ready_i) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL out_unexpected: got sel %0d data %0h expected no word", select_o, data_o);
        end else begin
          w = sb.pop_front();
          chk("sb_select", select_o, w.sel);
          chk("sb_data", data_o, w.data);
        end
      end
    end
  end
  initial begin
    logic [C*DW-1:0] d;
    logic [C-1:0] pv;
    logic [DW-1:0] pd [C];
    d = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    repeat (2) step(1, 0, '1, 1, d);
    chk("rst_data", data_o, 0);
    chk("rst_select", select_o, 0);
    step(0, 0, '1, 1, d);
    chk("first_grant", ready_o, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '1, 1, d);
      chk("rr_sel", select_o, i % 4);
      chk("rr_data", data_o, 16'hA000 + i % 4);
      chk("np2_sel", sel3, (i % 2) ? 2 : 0);
      chk("np2_data", data3_o, (i % 2) ? 16'hC002 : 16'hC000);
    end
    repeat (3) begin
      step(0, 0, '1, 0, d);
      chk("stall_sel", select_o, 1);
      chk("stall_data", data_o, 16'hA001);
      chk("stall_ready", ready_o, 0);
    end
    step(0, 0, '1, 1, d);
    step(0, 0, '1, 0, d);
    chk("after_stall_sel", select_o, 2);
    chk("after_stall_valid", valid_o, 1);
    step(1, 0, '1, 0, d);
    step(0, 0, '1, 1, d);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_sel", select_o, 0);
    step(0, 0, '1, 1, d);
    chk("post_rst_sel", select_o, 0);
    step(0, 1, 4'b1010, 1, d);
    repeat (4) begin
      step(0, 1, 4'b1010, 1, d);
      chk("fixed_sel", select_o, 1);
    end
    step(0, 0, 4'b1010, 1, d);
    chk("mode_switch_ready", ready_o, 4'b1000);
    step(0, 0, 4'b0000, 1, d);
    chk("mode_switch_sel", select_o, 3);
    pv = '0;
    for (int k = 0; k < C; k++) pd[k] = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < C; k++)
        if (!pv[k] || last_g == k) begin
          pv[k] = 1'($urandom_range(0, 1));
          pd[k] = DW'($urandom);
        end
      for (int k = 0; k < C; k++) d[k*DW +: DW] = pd[k];
      step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), pv, $urandom_range(0, 9) < 7, d);
    end
    repeat (3) step(0, 0, '0, 1, d);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
